// File: rtl/muldiv_sched.sv
// Iterative 32x32 multiply / restoring divide sequencer that owns the MIPS HI/LO registers.
// One operand bit per cycle for 32 cycles, then a sign-fix cycle that writes HI/LO.
module muldiv_sched (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [5:0]  func_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hilo_rdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  // a: multiplicand / divisor; b: multiplier / dividend shifting into quotient
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic        is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

  logic        is_md, signed_op, accept, done;
  logic [31:0] rs_mag, rt_mag, quot_fix, rem_fix, div_diff;
  logic [32:0] mul_sum, div_shift;
  logic [63:0] prod_fix;
  logic        div_ge;

  assign is_md     = (func_i >= F_MFHI && func_i <= F_MTLO) ||
                     (func_i >= F_MULT && func_i <= F_DIVU);
  assign signed_op = (func_i == F_MULT) || (func_i == F_DIV);
  assign rs_mag    = (signed_op && rs_val_i[31]) ? -rs_val_i : rs_val_i;
  assign rt_mag    = (signed_op && rt_val_i[31]) ? -rt_val_i : rt_val_i;
  assign accept    = start_i && !flush_i && (state_q == S_IDLE);

  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
  // Partial remainder is always < divisor, so the trial result fits 32 bits
  assign div_shift = {rem_q, b_q[31]};
  assign div_ge    = div_shift >= {1'b0, a_q};
  assign div_diff  = div_shift[31:0] - a_q;

  assign prod_fix  = neg_lo_q ? -acc_q : acc_q;
  assign quot_fix  = neg_lo_q ? -b_q   : b_q;
  assign rem_fix   = neg_hi_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    done     = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        case (func_i)
          F_MULT, F_MULTU: begin
            a_d      = rs_mag;
            b_d      = rt_mag;
            acc_d    = '0;
            cnt_d    = '0;
            neg_lo_d = signed_op && (rs_val_i[31] ^ rt_val_i[31]);
            neg_hi_d = 1'b0;
            is_div_d = 1'b0;
            state_d  = S_MUL;
          end
          F_DIV, F_DIVU: begin
            a_d      = rt_mag;
            b_d      = rs_mag;
            rem_d    = '0;
            cnt_d    = '0;
            neg_lo_d = signed_op && (rs_val_i[31] ^ rt_val_i[31]);
            neg_hi_d = signed_op && rs_val_i[31];
            is_div_d = 1'b1;
            state_d  = S_DIV;
          end
          F_MTHI:  hi_d = rs_val_i;
          F_MTLO:  lo_d = rs_val_i;
          default: ;
        endcase
      end
      S_MUL: begin
        acc_d   = {mul_sum, acc_q[31:1]};
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
        if (flush_i) state_d = S_IDLE;
      end
      S_DIV: begin
        rem_d   = div_ge ? div_diff : div_shift[31:0];
        b_d     = {b_q[30:0], div_ge};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
        if (flush_i) state_d = S_IDLE;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          done = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk_i) begin
    acc_q    <= acc_d;
    a_q      <= a_d;
    b_q      <= b_d;
    rem_q    <= rem_d;
    is_div_q <= is_div_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
  end

  assign stall_o      = start_i && is_md && (state_q != S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done;
  assign hilo_rdata_o = (func_i == F_MFHI) ? hi_q :
                        (func_i == F_MFLO) ? lo_q : 32'd0;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Iterative multiply/divide controller and HI/LO register owner for the MIPS EX stage. It accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO requests, identified by their R-type function code. It sequences a shared 32-cycle shift-add/restoring-divide datapath and stalls the pipeline while HI/LO are not yet valid. No traps are raised: divide-by-zero yields a defined result.

## Interface
- Parameters: none; operand width is fixed at 32.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: EX-stage request valid; held by the requester while `stall`=1.
- `func` in 6: function code. MFHI=16, MTHI=17, MFLO=18, MTLO=19, MULT=24, MULTU=25, DIV=26, DIVU=27. Other codes are ignored.
- `rs_val` in 32: rs operand (dividend / multiplicand / MT source).
- `rt_val` in 32: rt operand (divisor / multiplier).
- `flush` in 1: cancel any in-flight operation (exception or branch kill).
- `stall` out 1: combinational; request cannot be accepted this cycle.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse; HI/LO are updated at the end of this cycle.
- `hilo_rdata` out 32: combinational HI (MFHI) or LO (MFLO) read; 0 for other funcs.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- **IDLE + start + MULT/MULTU**
  - Latch magnitudes: |rs|,|rt| for MULT; raw operands for MULTU.
  - Latch result sign: sign(rs)^sign(rt) for MULT; 0 for MULTU.
  - Clear the 64-bit accumulator and cnt=0. Next state MUL.
- **IDLE + start + DIV/DIVU**
  - Latch magnitudes as above.
  - Quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs). Both are 0 for DIVU.
  - Next state DIV.
- **MUL**: one multiplier bit per cycle, add-shift into the 64-bit product. After 32 iterations (cnt==31) go to FIX.
- **DIV**: restoring division, one quotient bit per cycle.
  - Trial subtract the 33-bit partial remainder; restore if negative.
  - After 32 iterations go to FIX.
- **FIX**
  - Negate the product, quotient and/or remainder per the latched signs.
  - Assert `done`; write HI/LO at the closing edge.
  - MUL: HI=product[63:32], LO=product[31:0].
  - DIV: LO=quotient, HI=remainder.
  - Next state IDLE.
- **Divide by zero**: no special path; restoring yields all-ones quotient magnitude and remainder |rs|.
  - DIVU x/0: LO=0xFFFFFFFF, HI=x.
  - DIV x/0: LO=0xFFFFFFFF if x>=0, else 0x00000001; HI=x.
- **Overflow**: DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- **MTHI/MTLO in IDLE**: write `rs_val` to HI/LO at the next edge. No busy, no done.
- **MFHI/MFLO in IDLE**: `hilo_rdata` is valid the same cycle.
- **`stall`** = start & (func ∈ {16,17,18,19,24,25,26,27}) & (state≠IDLE).
  - Non-muldiv funcs never stall and are ignored.
- **`flush`**
  - In MUL/DIV/FIX: next state IDLE, HI/LO unchanged, `done` forced 0.
  - In IDLE: suppresses acceptance of a same-cycle start, including MT writes.
- `busy` = (state≠IDLE).

## Timing
- Reset: state=IDLE, hi=0, lo=0, cnt=0, busy=0, done=0. Datapath registers are don't-care.
- Start accepted in cycle 0 (edge E0).
  - MUL/DIV iterate in cycles 1..32; FIX in cycle 33 (`done`=1).
  - New HI/LO are visible from cycle 34.
  - `busy`=1 in cycles 1..33.
- A new start is accepted in cycle 34 at the earliest. There is no back-to-back acceptance during FIX: `stall`=1 in FIX.
- MT latency: 1 edge. MF latency: 0 (combinational).
- A same-cycle `rst_n`=0 overrides `flush` and `start`.
- Reset mid-operation returns to the reset values at the next edge.

## Test plan
- **Signed multiply**: MULT rs=0xFFFFFFFE (-2), rt=0x00000003.
  - Required: `done` in cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFFA from cycle 34.
  - MULTU with the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- **Signed divide**: DIV rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1.
- **Corner divides**:
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
  - DIV 0xFFFFFFFB/0 → LO=0x00000001, HI=0xFFFFFFFB.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Stall on busy**: MFLO issued in cycle 5 of a MULT.
  - Required: `stall`=1 through cycle 33, 0 in cycle 34.
  - In cycle 34, `hilo_rdata` equals the new LO.
- **Flush**: flush in cycle 20 of a DIV.
  - Required: IDLE at cycle 21, `busy`=0, HI/LO keep their prior values, no `done` pulse.
  - Also: flush together with MTHI in IDLE → HI unchanged.
- **Reset**:
  - `rst_n`=0 in cycle 10 of a MUL → hi=lo=0, busy=0 next cycle.
  - MTLO 0x12345678, then MFLO → `hilo_rdata`=0x12345678 one cycle later.
